pipe_stall_regs: RTL and testbench

- Implements the IF/ID and ID/EX pipeline registers of the 5-stage MIPS core. It acts on the hold/bubble commands produced by the load-use hazard detector: PCWrite, IFIDWrite and stall.
- Returns IDEX_MemRead and IDEX_RegRt to the hazard detector, closing that loop.
- Also handles the branch/jump flush from ID and a global cache-miss freeze (mem_stall).
- Keeps saturating stall and flush event counters for performance debug.

---
 rtl/pipe_pkg.sv | 26 ++
 rtl/sat_counter.sv | 22 ++
 rtl/pipe_stall_regs.sv | 116 +++++++++++
 tb/tb_pipe_stall_regs.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the IF/ID and ID/EX pipeline registers:
// NOP encodings, control-bundle bit positions and the register-index type.
package pipe_pkg;

    localparam int CTRL_BITS = 10;

    // sll $0,$0,0 -- the canonical MIPS NOP
    localparam logic [31:0]          NOP_INSTR = 32'h0000_0000;
    // All-zero control bundle: no write, no memory access, no branch
    localparam logic [CTRL_BITS-1:0] CTRL_NOP  = '0;

    // Bit positions inside the ID control bundle
    localparam int CTRL_REGDST_BIT   = 0;
    localparam int CTRL_ALUSRC_BIT   = 1;
    localparam int CTRL_MEMTOREG_BIT = 2;
    localparam int CTRL_MEMREAD_BIT  = 3;
    localparam int CTRL_MEMWRITE_BIT = 4;
    localparam int CTRL_REGWRITE_BIT = 5;
    localparam int CTRL_BRANCH_BIT   = 6;
    localparam int CTRL_ALUOP0_BIT   = 7;
    localparam int CTRL_ALUOP1_BIT   = 8;
    localparam int CTRL_JUMP_BIT     = 9;

    typedef logic [4:0] regidx_t;

endpackage

// File: rtl/sat_counter.sv
// Enabled up-counter that sticks at its all-ones value instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] count
);

    // Count enabled edges, holding once the maximum value is reached
    always_ff @(posedge clk) begin
        // NOTE: reset is sampled on the clock edge (synchronous), and all state
        // updates use non-blocking assignments so every flop sees pre-edge values.
        if (rst) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipe_stall_regs.sv
// IF/ID and ID/EX pipeline registers of the 5-stage MIPS core, driven by the
// load-use hazard detector (PCWrite/IFIDWrite/stall), the ID branch flush and
// the global cache-miss freeze, plus saturating stall/flush event counters.
module pipe_stall_regs
    import pipe_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int CTRL_W      = 10,
    parameter int MEMREAD_BIT = 3,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] if_pc4,
    input  logic [DATA_W-1:0] if_instr,
    input  logic              PCWrite,
    input  logic              IFIDWrite,
    input  logic              stall,
    input  logic              flush,
    input  logic              mem_stall,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  regidx_t           id_rs,
    input  regidx_t           id_rt,
    input  regidx_t           id_rd,
    output logic              pc_en,
    output logic [DATA_W-1:0] ifid_pc4,
    output logic [DATA_W-1:0] ifid_instr,
    output logic [CTRL_W-1:0] idex_ctrl,
    output logic [DATA_W-1:0] idex_rs_data,
    output logic [DATA_W-1:0] idex_rt_data,
    output logic [DATA_W-1:0] idex_imm,
    output regidx_t           idex_rs,
    output regidx_t           idex_rt,
    output regidx_t           idex_rd,
    output logic              IDEX_MemRead,
    output regidx_t           IDEX_RegRt,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    // A load-use stall wins over a flush: the branch operands are not valid
    // yet, so the branch re-resolves next cycle.
    logic flush_q;
    assign flush_q = flush & ~stall;

    // PC advances only when the hazard detector allows it and no cache miss
    assign pc_en = PCWrite & ~mem_stall;

    // IF/ID: freeze > hold > flush to NOP > load
    always_ff @(posedge clk) begin
        if (rst) begin
            ifid_pc4   <= '0;
            ifid_instr <= DATA_W'(NOP_INSTR);
        end else if (!mem_stall && IFIDWrite) begin
            if (flush_q) begin
                ifid_pc4   <= '0;
                ifid_instr <= DATA_W'(NOP_INSTR);
            end else begin
                ifid_pc4   <= if_pc4;
                ifid_instr <= if_instr;
            end
        end
    end

    // ID/EX: freeze > bubble > load; the branch in ID is never flushed here
    always_ff @(posedge clk) begin
        if (rst) begin
            idex_ctrl    <= CTRL_W'(CTRL_NOP);
            idex_rs_data <= '0;
            idex_rt_data <= '0;
            idex_imm     <= '0;
            idex_rs      <= '0;
            idex_rt      <= '0;
            idex_rd      <= '0;
        end else if (!mem_stall) begin
            // Operand data loads even on a bubble; it is ignored under NOP control
            idex_rs_data <= id_rs_data;
            idex_rt_data <= id_rt_data;
            idex_imm     <= id_imm;
            if (stall) begin
                idex_ctrl <= CTRL_W'(CTRL_NOP);
                idex_rs   <= '0;
                idex_rt   <= '0;
                idex_rd   <= '0;
            end else begin
                idex_ctrl <= id_ctrl;
                idex_rs   <= id_rs;
                idex_rt   <= id_rt;
                idex_rd   <= id_rd;
            end
        end
    end

    // Feedback to the hazard detector comes from registered ID/EX state, so a
    // bubble releases the stall after exactly one cycle.
    assign IDEX_MemRead = idex_ctrl[MEMREAD_BIT];
    assign IDEX_RegRt   = idex_rt;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (stall & ~mem_stall),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (flush_q & ~mem_stall),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_stall_regs.sv
// Self-checking bench for pipe_stall_regs: directed hazard scenarios followed
// by random traffic, all compared against a stage-level reference model.
module tb_pipe_stall_regs;
    import pipe_pkg::*;

    localparam int DATA_W      = 32;
    localparam int CTRL_W      = 10;
    localparam int MEMREAD_BIT = CTRL_MEMREAD_BIT;
    localparam int CNT_W       = 4;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    logic              clk;
    logic              rst;
    logic [DATA_W-1:0] if_pc4, if_instr;
    logic              PCWrite, IFIDWrite, stall, flush, mem_stall;
    logic [CTRL_W-1:0] id_ctrl;
    logic [DATA_W-1:0] id_rs_data, id_rt_data, id_imm;
    regidx_t           id_rs, id_rt, id_rd;
    logic              pc_en;
    logic [DATA_W-1:0] ifid_pc4, ifid_instr;
    logic [CTRL_W-1:0] idex_ctrl;
    logic [DATA_W-1:0] idex_rs_data, idex_rt_data, idex_imm;
    regidx_t           idex_rs, idex_rt, idex_rd;
    logic              IDEX_MemRead;
    regidx_t           IDEX_RegRt;
    logic [CNT_W-1:0]  stall_cnt, flush_cnt;

    pipe_stall_regs #(
        .DATA_W(DATA_W), .CTRL_W(CTRL_W), .MEMREAD_BIT(MEMREAD_BIT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .if_pc4(if_pc4), .if_instr(if_instr),
        .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .stall(stall), .flush(flush),
        .mem_stall(mem_stall), .id_ctrl(id_ctrl), .id_rs_data(id_rs_data),
        .id_rt_data(id_rt_data), .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt),
        .id_rd(id_rd), .pc_en(pc_en), .ifid_pc4(ifid_pc4), .ifid_instr(ifid_instr),
        .idex_ctrl(idex_ctrl), .idex_rs_data(idex_rs_data), .idex_rt_data(idex_rt_data),
        .idex_imm(idex_imm), .idex_rs(idex_rs), .idex_rt(idex_rt), .idex_rd(idex_rd),
        .IDEX_MemRead(IDEX_MemRead), .IDEX_RegRt(IDEX_RegRt),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: the instruction sitting in each stage plus event tallies
    logic [DATA_W-1:0] m_ifid_pc4, m_ifid_instr;
    logic [CTRL_W-1:0] m_idex_ctrl;
    logic [DATA_W-1:0] m_idex_rs_data, m_idex_rt_data, m_idex_imm;
    regidx_t           m_idex_rs, m_idex_rt, m_idex_rd;
    int                m_stall_cnt, m_flush_cnt;

    logic [CTRL_W-1:0] rtype_ctrl, lw_ctrl, sw_ctrl, beq_ctrl, j_ctrl;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently driven
    task automatic model_edge();
        bit taken_branch;
        bit bubble;
        if (rst) begin
            m_ifid_pc4 = '0; m_ifid_instr = '0; m_idex_ctrl = '0;
            m_idex_rs_data = '0; m_idex_rt_data = '0; m_idex_imm = '0;
            m_idex_rs = '0; m_idex_rt = '0; m_idex_rd = '0;
            m_stall_cnt = 0; m_flush_cnt = 0;
        end else if (!mem_stall) begin
            bubble       = stall;
            taken_branch = flush && !stall;
            if (IFIDWrite) begin
                m_ifid_pc4   = taken_branch ? '0 : if_pc4;
                m_ifid_instr = taken_branch ? '0 : if_instr;
            end
            m_idex_rs_data = id_rs_data;
            m_idex_rt_data = id_rt_data;
            m_idex_imm     = id_imm;
            m_idex_ctrl    = bubble ? '0 : id_ctrl;
            m_idex_rs      = bubble ? '0 : id_rs;
            m_idex_rt      = bubble ? '0 : id_rt;
            m_idex_rd      = bubble ? '0 : id_rd;
            if (bubble)       m_stall_cnt = (m_stall_cnt + 1 > CNT_MAX) ? CNT_MAX : m_stall_cnt + 1;
            if (taken_branch) m_flush_cnt = (m_flush_cnt + 1 > CNT_MAX) ? CNT_MAX : m_flush_cnt + 1;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".ifid_pc4"},     ifid_pc4,     m_ifid_pc4);
        chk({tag, ".ifid_instr"},   ifid_instr,   m_ifid_instr);
        chk({tag, ".idex_ctrl"},    idex_ctrl,    m_idex_ctrl);
        chk({tag, ".idex_rs_data"}, idex_rs_data, m_idex_rs_data);
        chk({tag, ".idex_rt_data"}, idex_rt_data, m_idex_rt_data);
        chk({tag, ".idex_imm"},     idex_imm,     m_idex_imm);
        chk({tag, ".idex_rs"},      idex_rs,      m_idex_rs);
        chk({tag, ".idex_rt"},      idex_rt,      m_idex_rt);
        chk({tag, ".idex_rd"},      idex_rd,      m_idex_rd);
        chk({tag, ".memread"},      IDEX_MemRead, m_idex_ctrl[MEMREAD_BIT]);
        chk({tag, ".regrt"},        IDEX_RegRt,   m_idex_rt);
        chk({tag, ".stall_cnt"},    stall_cnt,    m_stall_cnt);
        chk({tag, ".flush_cnt"},    flush_cnt,    m_flush_cnt);
    endtask

    // One cycle: check pc_en before the edge, then the registered state after it
    task automatic step(input string tag);
        #1;
        chk({tag, ".pc_en"}, pc_en, PCWrite & ~mem_stall);
        model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic rand_data();
        if_pc4     = $urandom;
        if_instr   = $urandom;
        id_rs_data = $urandom;
        id_rt_data = $urandom;
        id_imm     = $urandom;
        id_rs      = regidx_t'($urandom_range(0, 31));
        id_rt      = regidx_t'($urandom_range(0, 31));
        id_rd      = regidx_t'($urandom_range(0, 31));
        id_ctrl    = CTRL_W'($urandom);
    endtask

    task automatic set_cmds(input logic pcw, input logic ifw, input logic st,
                            input logic fl, input logic ms);
        PCWrite = pcw; IFIDWrite = ifw; stall = st; flush = fl; mem_stall = ms;
    endtask

    initial begin
        logic [CTRL_W-1:0] pick [5];

        rtype_ctrl = '0;
        rtype_ctrl[CTRL_REGDST_BIT]   = 1'b1;
        rtype_ctrl[CTRL_REGWRITE_BIT] = 1'b1;
        rtype_ctrl[CTRL_ALUOP1_BIT]   = 1'b1;
        lw_ctrl = '0;
        lw_ctrl[CTRL_ALUSRC_BIT]   = 1'b1;
        lw_ctrl[CTRL_MEMTOREG_BIT] = 1'b1;
        lw_ctrl[CTRL_MEMREAD_BIT]  = 1'b1;
        lw_ctrl[CTRL_REGWRITE_BIT] = 1'b1;
        sw_ctrl = '0;
        sw_ctrl[CTRL_ALUSRC_BIT]   = 1'b1;
        sw_ctrl[CTRL_MEMWRITE_BIT] = 1'b1;
        beq_ctrl = '0;
        beq_ctrl[CTRL_BRANCH_BIT] = 1'b1;
        beq_ctrl[CTRL_ALUOP0_BIT] = 1'b1;
        j_ctrl = '0;
        j_ctrl[CTRL_JUMP_BIT] = 1'b1;
        pick = '{rtype_ctrl, lw_ctrl, sw_ctrl, beq_ctrl, j_ctrl};

        // Reset with random inputs on every port
        rst = 1'b1;
        rand_data();
        set_cmds(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
        @(posedge clk);
        #1;
        step("rst0");
        rand_data();
        set_cmds(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        step("rst1");
        chk("rst.ifid_instr_nop", ifid_instr, 32'h0);
        chk("rst.idex_ctrl_nop", idex_ctrl, 10'h0);

        // Load a lw $8 into ID/EX while its successor is fetched
        rst = 1'b0;
        set_cmds(1, 1, 0, 0, 0);
        rand_data();
        if_instr = 32'h8D28_0000;
        id_ctrl  = lw_ctrl;
        id_rt    = 5'd8;
        step("load_lw");
        chk("load_lw.memread", IDEX_MemRead, 1'b1);
        chk("load_lw.regrt", IDEX_RegRt, 5'd8);

        // Load-use: hold PC and IF/ID, bubble ID/EX for one cycle
        set_cmds(0, 0, 1, 0, 0);
        rand_data();
        if_instr = 32'h0109_5020;
        id_ctrl  = rtype_ctrl;
        #1;
        chk("loaduse.pc_en_low", pc_en, 1'b0);
        step("loaduse");
        chk("loaduse.ifid_held", ifid_instr, 32'h8D28_0000);
        chk("loaduse.bubble_memread", IDEX_MemRead, 1'b0);
        chk("loaduse.stall_cnt", stall_cnt, 4'd1);

        // Stall released: the dependent add proceeds
        set_cmds(1, 1, 0, 0, 0);
        rand_data();
        id_ctrl = rtype_ctrl;
        step("release");

        // Taken branch in ID: IF/ID flushed, branch itself enters ID/EX
        set_cmds(1, 1, 0, 1, 0);
        rand_data();
        if_instr = 32'h8C02_0004;
        id_ctrl  = beq_ctrl;
        step("flush");
        chk("flush.ifid_nop", ifid_instr, 32'h0);
        chk("flush.idex_branch", idex_ctrl, beq_ctrl);
        chk("flush.flush_cnt", flush_cnt, 4'd1);

        // Refill IF/ID, then stall and flush together: the stall wins
        set_cmds(1, 1, 0, 0, 0);
        rand_data();
        if_instr = 32'h0085_1020;
        id_ctrl  = lw_ctrl;
        step("refill");
        set_cmds(0, 0, 1, 1, 0);
        rand_data();
        step("stall_flush");
        chk("stall_flush.ifid_held", ifid_instr, 32'h0085_1020);
        chk("stall_flush.idex_bubble", idex_ctrl, 10'h0);
        chk("stall_flush.flush_cnt", flush_cnt, 4'd1);
        chk("stall_flush.stall_cnt", stall_cnt, 4'd2);

        // Cache freeze during a stall: nothing moves for five cycles
        set_cmds(1, 1, 0, 0, 0);
        rand_data();
        if_instr = 32'h0085_1020;
        id_ctrl  = lw_ctrl;
        step("pre_freeze");
        for (int i = 0; i < 5; i++) begin
            rand_data();
            set_cmds(0, 0, 1, 1'($urandom), 1);
            step($sformatf("freeze%0d", i));
        end
        chk("freeze.idex_ctrl", idex_ctrl, lw_ctrl);
        chk("freeze.stall_cnt", stall_cnt, 4'd2);
        chk("freeze.flush_cnt", flush_cnt, 4'd1);
        set_cmds(0, 0, 1, 0, 0);
        rand_data();
        step("unfreeze");
        chk("unfreeze.bubble", idex_ctrl, 10'h0);
        chk("unfreeze.stall_cnt", stall_cnt, 4'd3);

        // Hold stall long enough to saturate the counter
        for (int i = 0; i < 20; i++) begin
            rand_data();
            set_cmds(0, 0, 1, 0, 0);
            step($sformatf("sat%0d", i));
        end
        chk("sat.stall_cnt_max", stall_cnt, 4'd15);

        // Random traffic with occasional resets and inconsistent commands
        for (int i = 0; i < 400; i++) begin
            rand_data();
            if ($urandom_range(0, 4) != 0) id_ctrl = pick[$urandom_range(0, 4)];
            rst = ($urandom_range(0, 49) == 0);
            set_cmds(($urandom_range(0, 4) != 0), ($urandom_range(0, 4) != 0),
                     ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
                     ($urandom_range(0, 6) == 0));
            step($sformatf("rnd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
